// File: rtl/menu_controller_pkg.sv
// Shared types and constants for the menu/game sequencer and its keyboard front end.
package menu_pkg;

  typedef enum logic [2:0] {
    MENU,
    FADE_OUT,
    PLAY,
    PAUSED,
    GAME_OVER
  } menu_state_t;

  localparam logic [7:0] KC_UP    = 8'h1A;
  localparam logic [7:0] KC_DOWN  = 8'h16;
  localparam logic [7:0] KC_ENTER = 8'h28;
  localparam logic [7:0] KC_PAUSE = 8'h13;
  localparam logic [7:0] KC_ESC   = 8'h29;

  localparam int         FRAME_TICK_Y = 480;
  localparam logic [3:0] FADE_FULL    = 4'd15;

endpackage

// File: rtl/menu_controller_key_event_detect.sv
// Turns a level keycode into a single registered event per new key press.
module key_event_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_keycode,
  output logic       o_key_evt,
  output logic [7:0] o_key_code
);

  logic [7:0] r_keycode_q;
  logic       r_key_evt;
  logic [7:0] r_key_code;

  // A held key matches its own delayed copy, so it fires only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keycode_q <= 8'd0;
      r_key_evt   <= 1'b0;
      r_key_code  <= 8'd0;
    end else begin
      r_keycode_q <= i_keycode;
      r_key_evt   <= (i_keycode != 8'd0) && (i_keycode != r_keycode_q);
      r_key_code  <= i_keycode;
    end
  end

  assign o_key_evt  = r_key_evt;
  assign o_key_code = r_key_code;

endmodule

// File: rtl/menu_controller.sv
// Game-state sequencer: menu cursor, frame-synchronous fade, play/pause/game-over flow.
module menu_controller
  import menu_pkg::*;
#(
  parameter int         NUM_OPTIONS     = 3,
  parameter int         GAMEOVER_FRAMES = 120,
  parameter logic [7:0] KEY_UP          = KC_UP,
  parameter logic [7:0] KEY_DOWN        = KC_DOWN,
  parameter logic [7:0] KEY_ENTER       = KC_ENTER,
  parameter logic [7:0] KEY_PAUSE       = KC_PAUSE,
  parameter logic [7:0] KEY_ESC         = KC_ESC
) (
  input  logic                           vga_clk,
  input  logic                           reset,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  input  logic [7:0]                     keycode,
  input  logic                           game_over,
  output logic                           menu_active,
  output logic [$clog2(NUM_OPTIONS)-1:0] sel_index,
  output logic [$clog2(NUM_OPTIONS)-1:0] game_mode,
  output logic [3:0]                     fade_level,
  output logic                           game_run,
  output logic                           game_reset,
  output logic                           paused
);

  localparam int                SEL_W    = $clog2(NUM_OPTIONS);
  localparam int                CNT_W    = $clog2(GAMEOVER_FRAMES + 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_OPTIONS - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(GAMEOVER_FRAMES);

  logic             w_key_evt;
  logic [7:0]       w_key_code;
  logic             w_key_ok;

  logic             r_frame_tick;
  menu_state_t      r_state, w_state_nx;
  logic [SEL_W-1:0] r_sel, w_sel_nx;
  logic [SEL_W-1:0] r_mode, w_mode_nx;
  logic [3:0]       r_fade, w_fade_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_pend, w_pend_nx;
  logic             r_greset, w_greset_nx;
  logic             r_menu_active, r_run, r_paused;

  key_event_detect u_key (
    .clk        (vga_clk),
    .rst        (reset),
    .i_keycode  (keycode),
    .o_key_evt  (w_key_evt),
    .o_key_code (w_key_code)
  );

  assign w_key_ok = w_key_evt && !r_pend;

  always_comb begin
    w_state_nx  = r_state;
    w_sel_nx    = r_sel;
    w_mode_nx   = r_mode;
    w_fade_nx   = r_fade;
    w_cnt_nx    = r_cnt;
    w_pend_nx   = r_pend;
    w_greset_nx = 1'b0;
    case (r_state)
      MENU: begin
        if (w_key_evt) begin
          if (w_key_code == KEY_UP) begin
            w_sel_nx = (r_sel == '0) ? SEL_LAST : r_sel - 1'b1;
          end else if (w_key_code == KEY_DOWN) begin
            w_sel_nx = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
          end else if (w_key_code == KEY_ENTER) begin
            w_mode_nx  = r_sel;
            w_state_nx = FADE_OUT;
          end
        end
      end
      FADE_OUT: begin
        // Level 0 is held for one full frame, giving 16 frames of fade.
        if (r_frame_tick) begin
          if (r_fade == 4'd0) begin
            w_state_nx  = PLAY;
            w_greset_nx = 1'b1;
          end else begin
            w_fade_nx = r_fade - 4'd1;
          end
        end
      end
      PLAY: begin
        if (game_over) begin
          w_state_nx = GAME_OVER;
          w_cnt_nx   = '0;
          w_pend_nx  = 1'b0;
        end else if (r_pend && r_frame_tick) begin
          w_state_nx = MENU;
          w_fade_nx  = FADE_FULL;
          w_pend_nx  = 1'b0;
        end else if (w_key_ok) begin
          if (w_key_code == KEY_PAUSE) w_state_nx = PAUSED;
          else if (w_key_code == KEY_ESC) w_pend_nx = 1'b1;
        end
      end
      PAUSED: begin
        if (r_pend && r_frame_tick) begin
          w_state_nx = MENU;
          w_fade_nx  = FADE_FULL;
          w_pend_nx  = 1'b0;
        end else if (w_key_ok) begin
          if (w_key_code == KEY_PAUSE) w_state_nx = PLAY;
          else if (w_key_code == KEY_ESC) w_pend_nx = 1'b1;
        end
      end
      GAME_OVER: begin
        if (r_pend && r_frame_tick) begin
          w_state_nx = MENU;
          w_fade_nx  = FADE_FULL;
          w_pend_nx  = 1'b0;
        end else begin
          if (r_frame_tick && (r_cnt != CNT_SAT)) w_cnt_nx = r_cnt + 1'b1;
          if (w_key_ok && (w_key_code == KEY_ENTER) && (r_cnt == CNT_SAT)) w_pend_nx = 1'b1;
        end
      end
      default: w_state_nx = MENU;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_frame_tick  <= 1'b0;
      r_state       <= MENU;
      r_sel         <= '0;
      r_mode        <= '0;
      r_fade        <= FADE_FULL;
      r_cnt         <= '0;
      r_pend        <= 1'b0;
      r_greset      <= 1'b0;
      r_menu_active <= 1'b1;
      r_run         <= 1'b0;
      r_paused      <= 1'b0;
    end else begin
      r_frame_tick  <= (DrawX == 10'd0) && (DrawY == 10'(FRAME_TICK_Y));
      r_state       <= w_state_nx;
      r_sel         <= w_sel_nx;
      r_mode        <= w_mode_nx;
      r_fade        <= w_fade_nx;
      r_cnt         <= w_cnt_nx;
      r_pend        <= w_pend_nx;
      r_greset      <= w_greset_nx;
      r_menu_active <= (w_state_nx == MENU) || (w_state_nx == FADE_OUT);
      r_run         <= (w_state_nx == PLAY);
      r_paused      <= (w_state_nx == PAUSED);
    end
  end

  assign menu_active = r_menu_active;
  assign sel_index   = r_sel;
  assign game_mode   = r_mode;
  assign fade_level  = r_fade;
  assign game_run    = r_run;
  assign game_reset  = r_greset;
  assign paused      = r_paused;

endmodule

// File: tb/tb_menu_controller.sv
// Randomized bench for menu_controller against a tick/event-level reference model.
module tb_menu_controller;

  localparam int N  = 3;
  localparam int GF = 120;
  localparam logic [7:0] K_UP    = 8'h1A;
  localparam logic [7:0] K_DOWN  = 8'h16;
  localparam logic [7:0] K_ENTER = 8'h28;
  localparam logic [7:0] K_PAUSE = 8'h13;
  localparam logic [7:0] K_ESC   = 8'h29;
  localparam int P_MENU = 0, P_FADE = 1, P_PLAY = 2, P_PAUSE = 3, P_OVER = 4;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [9:0] DrawX, DrawY;
  logic [7:0] keycode;
  logic       game_over;
  logic       menu_active;
  logic [1:0] sel_index, game_mode;
  logic [3:0] fade_level;
  logic       game_run, game_reset, paused;

  int n_checks = 0;
  int n_errors = 0;

  // model: screen phase plus counts of frame ticks seen in fade and game-over
  int   m_phase, m_sel, m_mode, m_fticks, m_oticks;
  bit   m_pend, m_greset;
  bit   d_evt, d_tick;
  logic [7:0] d_code, m_prevk;

  menu_controller #(.NUM_OPTIONS(N), .GAMEOVER_FRAMES(GF)) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .keycode     (keycode),
    .game_over   (game_over),
    .menu_active (menu_active),
    .sel_index   (sel_index),
    .game_mode   (game_mode),
    .fade_level  (fade_level),
    .game_run    (game_run),
    .game_reset  (game_reset),
    .paused      (paused)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_fade();
    if (m_phase == P_MENU) return 15;
    if (m_phase == P_FADE) return 15 - ((m_fticks > 15) ? 15 : m_fticks);
    return 0;
  endfunction

  task automatic check_all();
    chk("menu_active", 32'(menu_active), 32'((m_phase == P_MENU) || (m_phase == P_FADE)));
    chk("sel_index",   32'(sel_index),   32'(m_sel));
    chk("game_mode",   32'(game_mode),   32'(m_mode));
    chk("fade_level",  32'(fade_level),  32'(exp_fade()));
    chk("game_run",    32'(game_run),    32'(m_phase == P_PLAY));
    chk("game_reset",  32'(game_reset),  32'(m_greset));
    chk("paused",      32'(paused),      32'(m_phase == P_PAUSE));
  endtask

  task automatic model_reset();
    m_phase = P_MENU; m_sel = 0; m_mode = 0; m_fticks = 0; m_oticks = 0;
    m_pend = 0; m_greset = 0; d_evt = 0; d_tick = 0; d_code = 8'd0; m_prevk = 8'd0;
  endtask

  task automatic to_menu();
    m_phase = P_MENU;
    m_pend  = 0;
  endtask

  // Applies the events that reach the sequencer on the coming edge.
  task automatic model_edge(input bit go);
    bit accept;
    m_greset = 0;
    case (m_phase)
      P_MENU: if (d_evt) begin
        if (d_code == K_UP) m_sel = (m_sel + N - 1) % N;
        else if (d_code == K_DOWN) m_sel = (m_sel + 1) % N;
        else if (d_code == K_ENTER) begin
          m_mode = m_sel; m_phase = P_FADE; m_fticks = 0;
        end
      end
      P_FADE: if (d_tick) begin
        m_fticks++;
        if (m_fticks == 16) begin m_phase = P_PLAY; m_greset = 1; end
      end
      P_PLAY: begin
        if (go) begin m_phase = P_OVER; m_oticks = 0; m_pend = 0; end
        else if (m_pend && d_tick) to_menu();
        else if (d_evt && !m_pend) begin
          if (d_code == K_PAUSE) m_phase = P_PAUSE;
          else if (d_code == K_ESC) m_pend = 1;
        end
      end
      P_PAUSE: begin
        if (m_pend && d_tick) to_menu();
        else if (d_evt && !m_pend) begin
          if (d_code == K_PAUSE) m_phase = P_PLAY;
          else if (d_code == K_ESC) m_pend = 1;
        end
      end
      default: begin
        if (m_pend && d_tick) to_menu();
        else begin
          accept = d_evt && !m_pend && (d_code == K_ENTER) && (m_oticks >= GF);
          if (d_tick) m_oticks++;
          if (accept) m_pend = 1;
        end
      end
    endcase
  endtask

  task automatic step(input logic [7:0] kc, input bit tk, input bit go);
    keycode   = kc;
    game_over = go;
    if (tk) begin
      DrawX = 10'd0; DrawY = 10'd480;
    end else if ($urandom_range(0, 3) == 0) begin
      DrawX = 10'd0; DrawY = 10'($urandom_range(0, 479));
    end else begin
      DrawX = 10'($urandom_range(1, 799)); DrawY = 10'($urandom_range(0, 524));
    end
    model_edge(go);
    d_evt   = (kc != 8'd0) && (kc != m_prevk);
    d_code  = kc;
    d_tick  = tk;
    m_prevk = kc;
    @(posedge vga_clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; keycode = 8'd0; game_over = 1'b0; DrawX = 10'd3; DrawY = 10'd3;
    @(posedge vga_clk); #1;
    model_reset();
    check_all();
    reset = 1'b0;
  endtask

  task automatic press(input logic [7:0] kc);
    step(kc, 0, 0); step(kc, 0, 0); step(8'd0, 0, 0); step(8'd0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(8'd0, 1, 0); step(8'd0, 0, 0);
    end
  endtask

  initial begin
    int  go_left;
    int  hold;
    logic [7:0] kc;
    logic [7:0] ktab [6];
    ktab = '{8'd0, K_UP, K_DOWN, K_ENTER, K_PAUSE, K_ESC};
    reset = 1'b1; keycode = 8'd0; game_over = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    model_reset();
    do_reset();
    chk("rst_sel", 32'(sel_index), 32'd0);
    chk("rst_fade", 32'(fade_level), 32'd15);

    // held key moves the cursor once; separate presses wrap
    for (int i = 0; i < 20; i++) step(K_DOWN, bit'(i % 2), 0);
    chk("hold_once", 32'(sel_index), 32'd1);
    step(8'd0, 0, 0); step(8'd0, 0, 0);
    press(K_DOWN);
    chk("down_2", 32'(sel_index), 32'd2);
    press(K_DOWN);
    chk("down_wrap", 32'(sel_index), 32'd0);
    press(K_UP);
    chk("up_wrap", 32'(sel_index), 32'd2);

    // select, fade with ignored keys, enter play
    press(K_ENTER);
    chk("mode_latch", 32'(game_mode), 32'd2);
    ticks(3);
    press(K_UP); press(K_ENTER); press(K_ESC);
    chk("fade_keys_sel", 32'(sel_index), 32'd2);
    chk("fade_at_3", 32'(fade_level), 32'd12);
    ticks(12);
    chk("fade_zero", 32'(fade_level), 32'd0);
    chk("still_menu", 32'(menu_active), 32'd1);
    ticks(1);
    chk("play_owner", 32'(menu_active), 32'd0);
    chk("play_run", 32'(game_run), 32'd1);

    // pause toggle, escape on frame boundary
    press(K_PAUSE);
    chk("paused_on", 32'(paused), 32'd1);
    press(K_PAUSE);
    chk("resume_run", 32'(game_run), 32'd1);
    press(K_ESC);
    for (int i = 0; i < 5; i++) step(8'd0, 0, 0);
    chk("esc_wait", 32'(menu_active), 32'd0);
    ticks(1);
    chk("esc_menu", 32'(menu_active), 32'd1);
    chk("esc_fade", 32'(fade_level), 32'd15);

    // game over wins over simultaneous pause; enter held off until saturated
    press(K_ENTER);
    ticks(16);
    step(K_PAUSE, 0, 0); step(K_PAUSE, 0, 1); step(8'd0, 0, 0);
    chk("over_paused", 32'(paused), 32'd0);
    chk("over_run", 32'(game_run), 32'd0);
    ticks(50);
    press(K_ENTER);
    ticks(3);
    chk("early_enter", 32'(menu_active), 32'd0);
    ticks(80);
    press(K_ENTER);
    chk("late_pending", 32'(menu_active), 32'd0);
    ticks(1);
    chk("late_menu", 32'(menu_active), 32'd1);

    // reset in the middle of a fade
    press(K_ENTER);
    ticks(8);
    chk("mid_fade", 32'(fade_level), 32'd7);
    do_reset();
    chk("rst_fade2", 32'(fade_level), 32'd15);
    chk("rst_sel2", 32'(sel_index), 32'd0);
    chk("rst_run2", 32'(game_run), 32'd0);

    // randomized play
    go_left = 0;
    for (int c = 0; c < 5000; ) begin
      int r;
      r = int'($urandom_range(0, 6));
      kc = (r == 6) ? 8'($urandom) : ktab[r];
      hold = int'($urandom_range(1, 4)) + int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        if (go_left == 0 && $urandom_range(0, 199) == 0) go_left = int'($urandom_range(1, 5));
        step((h < hold - 1 || hold == 1) ? kc : 8'd0, ($urandom_range(0, 2) == 0), go_left > 0);
        if (go_left > 0) go_left--;
        c++;
      end
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/menu_controller.md
Name: menu_controller

Overview:
- Game-state sequencer that shares the 640x480 screen between the menu sprite path and the game renderer.
- Decodes keyboard keycodes into single key events and moves a selection cursor over the menu options.
- Runs a frame-synchronous fade-out, then starts, pauses, ends and returns from play.
- Sits between the keyboard interface, the menu sprite/palette path (menu_active, sel_index, fade_level) and the game logic (game_run, game_reset, game_over).

Parameters:
- NUM_OPTIONS, 3, number of selectable menu entries; minimum 2.
- GAMEOVER_FRAMES, 120, frames the game-over screen holds before Enter is accepted.
- KEY_UP, 8'h1A, keycode for cursor up (W).
- KEY_DOWN, 8'h16, keycode for cursor down (S).
- KEY_ENTER, 8'h28, keycode for select.
- KEY_PAUSE, 8'h13, keycode for pause toggle (P).
- KEY_ESC, 8'h29, keycode for return to menu.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- keycode  in  8  current keyboard keycode; 0 = no key.
- game_over  in  1  level from game logic, end of match.
- menu_active  out  1  1 = menu sprite drives pixels; 0 = game renderer drives pixels.
- sel_index  out  $clog2(NUM_OPTIONS)  highlighted menu entry.
- game_mode  out  $clog2(NUM_OPTIONS)  entry latched on Enter.
- fade_level  out  4  menu brightness scale, 15 = full, 0 = black.
- game_run  out  1  game logic advances while 1.
- game_reset  out  1  one-cycle pulse clearing game state.
- paused  out  1  pause overlay enable.

Behaviour:
- Clock and reset: one clock, vga_clk; reset is synchronous, active-high.
- Reset values: state MENU; sel_index 0; game_mode 0; menu_active 1; fade_level 15; game_run 0; game_reset 0; paused 0; frame counter 0; pending flag 0; keycode_q 0.
- Reset asserted mid-fade or mid-play returns to these values on the next edge.
- frame_tick: registered one-cycle pulse, asserted the cycle after DrawX==0 && DrawY==480 (start of vertical blank).
- key_evt: registered one-cycle pulse when keycode!=0 && keycode!=keycode_q.
  - keycode_q registers keycode every cycle.
  - A held key produces exactly one event.
  - Release then re-press produces a new event.
- Key decode uses the keycode value from the event cycle. Unlisted keycodes are ignored.
- State machine; all outputs are registered:
  - MENU: menu_active=1, game_run=0, fade_level=15.
    - UP: sel_index decrements, wrapping 0 -> NUM_OPTIONS-1.
    - DOWN: sel_index increments, wrapping NUM_OPTIONS-1 -> 0.
    - ENTER: game_mode<=sel_index, go to FADE_OUT.
  - FADE_OUT: menu_active=1; keys ignored.
    - fade_level decrements by 1 on each frame_tick.
    - On the frame_tick where fade_level==0: go to PLAY and pulse game_reset in that same cycle. Total fade = 16 frames.
  - PLAY: menu_active=0, game_run=1.
    - game_over=1 -> GAME_OVER (frame counter cleared).
    - PAUSE -> PAUSED.
    - ESC -> set pending; go to MENU on next frame_tick.
  - PAUSED: game_run=0, paused=1.
    - PAUSE -> PLAY.
    - ESC -> set pending; go to MENU on next frame_tick.
  - GAME_OVER: game_run=0, menu_active=0.
    - Frame counter increments per frame_tick, saturating at GAMEOVER_FRAMES.
    - ENTER is accepted only once saturated; it sets pending -> MENU on next frame_tick. Earlier ENTER is dropped.
- Entry to MENU always resets fade_level to 15 and keeps sel_index. The pending flag clears on entry.
- Screen-ownership changes (menu_active edges) occur only in the cycle of a frame_tick, so there is no mid-frame tearing.
- While pending=1, further keys are ignored.
- Priority within one cycle: reset > game_over > key_evt. In PLAY, game_over with a simultaneous PAUSE/ESC goes to GAME_OVER. frame_tick coinciding with key_evt: the key is processed first, then pending is evaluated next tick.
- Width rules:
  - sel_index and game_mode use unsigned modulo-NUM_OPTIONS arithmetic (non-power-of-two handled by explicit compare).
  - fade_level never underflows below 0.
  - Frame counter is $clog2(GAMEOVER_FRAMES+1) bits.
- Latency: key to sel_index = 2 cycles (event register + state register).

Decomposition:
- Shared package menu_pkg:
  - state enum menu_state_t {MENU, FADE_OUT, PLAY, PAUSED, GAME_OVER};
  - keycode localparams;
  - FRAME_TICK_Y=480.
- One natural sub-module, key_event_detect (keycode_q register + key_evt/key_code output). It is reused by other keyboard consumers.

Test Plan:
- Reset, then keycode=8'h16 held 10 frames -> sel_index 0->1 once only. Release, press 8'h16 twice -> sel_index 1->2->0 (wrap).
- From MENU sel 0, press 8'h1A -> sel_index=2. Enter -> game_mode=2; fade_level steps 15..0 on successive frame_ticks. On the 16th frame_tick: menu_active=0, game_run=1, game_reset high exactly 1 cycle.
- Keys (Up/Enter/Esc) during FADE_OUT -> no effect on sel_index, game_mode or fade count.
- In PLAY, press 8'h13 -> paused=1, game_run=0. Press 8'h13 again -> game_run=1. Press 8'h29 mid-frame -> menu_active stays 0 until the cycle of the next frame_tick, then 1 with fade_level=15.
- In PLAY, assert game_over with keycode 8'h13 in the same cycle -> GAME_OVER, paused=0. Enter at frame 50 (GAMEOVER_FRAMES=120) ignored. Enter after frame 120 -> MENU on next frame_tick.
- Assert reset at fade_level=7 -> next edge MENU, fade_level=15, sel_index=0, game_run=0.
